pipe_register: RTL and testbench

- Parametrised, elastic multi-stage successor to the single D register.
- STAGES register slices, each with its own valid bit, chained with a valid/ready handshake.
- Adds per-stage bubble collapsing, backpressure, synchronous flush and an occupancy count.
- Sits between CPU pipeline stages and in datapath FIFOs-in-miniature, where a plain enable is no longer enough.

---
 rtl/pipe_register_pkg.sv | 15 +
 rtl/pipe_register_stage.sv | 56 +++++
 rtl/pipe_register.sv | 140 ++++++++++++++
 tb/tb_pipe_register.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_register_pkg.sv
// Purpose: shared constants and helpers for the elastic pipe register.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//   cnt_width(stages)  width of the occupancy counter, room for STAGES+1 entries
//   PIPE_MAX_STAGES    largest supported number of register slices
package pipe_pkg;

    localparam int PIPE_MAX_STAGES = 16;

    // The counter must hold 0..STAGES+1 (the +1 is the optional skid entry).
    function automatic int cnt_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// Purpose: one valid/data register slice of the elastic pipe.
// Latency: 1 cycle from up_* to dn_*.
// Backpressure: up_ready = !valid || dn_ready (combinational pass-through of ready).
// Ports:
//   clk, rst (async active-high), flush (sync, clears valid)
//   up_valid/up_ready/up_data   upstream handshake into this slice
//   dn_valid/dn_ready/dn_data   downstream handshake out of this slice
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    // Accepting while the current word leaves lets bubbles collapse.
    assign up_ready = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (up_ready) begin
            // Either refilled from upstream or emptied because the word moved on.
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_register.sv
// Purpose: parametrised elastic pipe of STAGES valid/ready register slices with flush and occupancy count.
// Latency: STAGES cycles input to output with out_ready high; 1 word/cycle throughput.
// Backpressure: combinational ready chain to in_ready; with PIPE_REGISTER_SKID_BUFFER_EN a skid entry makes in_ready a flop.
// Ports:
//   clk, rst (async active-high), flush (sync, drops all in-flight words)
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake, driven by the last slice
//   count                         registered number of occupied entries
// Optional build macro: PIPE_REGISTER_SKID_BUFFER_EN (one-entry skid buffer ahead of slice 0).
module pipe_register
    import pipe_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int STAGES     = 2,
    localparam int CNT_W      = cnt_width(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      count
);

    if (STAGES < 1 || STAGES > PIPE_MAX_STAGES) begin : g_bad_stages
        $error("pipe_register: STAGES must be within 1..PIPE_MAX_STAGES");
    end

    // Index i is the input of slice i; index STAGES is the output of the last slice.
    logic                  stg_vld [STAGES+1];
    logic [DATA_WIDTH-1:0] stg_dat [STAGES+1];

    logic                  in_fire;
    logic                  out_fire;
    logic [CNT_W-1:0]      count_q, count_d;

    // Ready is kept in per-slice signals so the combinational chain is not one looped array.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic up_rdy;
        logic dn_rdy;

        if (i == STAGES - 1) begin : g_last
            assign dn_rdy = out_ready;
        end else begin : g_mid
            assign dn_rdy = g_stage[i+1].up_rdy;
        end

        pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (stg_vld[i]),
            .up_ready (up_rdy),
            .up_data  (stg_dat[i]),
            .dn_valid (stg_vld[i+1]),
            .dn_ready (dn_rdy),
            .dn_data  (stg_dat[i+1])
        );
    end

`ifdef PIPE_REGISTER_SKID_BUFFER_EN
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  in_ready_q;

    // in_ready depends only on flops (and flush), never on out_ready.
    assign in_ready = in_ready_q && !flush;
    assign in_fire  = in_valid && in_ready;

    // A held skid word always goes first; otherwise the input bypasses straight into slice 0.
    assign stg_vld[0] = !flush && (skid_valid_q || in_fire);
    assign stg_dat[0] = skid_valid_q ? skid_data_q : in_data;

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low while the skid is full, so only draining is possible.
            if (g_stage[0].up_rdy) begin
                skid_valid_d = 1'b0;
            end
        end else if (in_fire && !g_stage[0].up_rdy) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= !skid_valid_d;
        end
    end
`else
    assign in_ready   = g_stage[0].up_rdy && !flush;
    assign in_fire    = in_valid && in_ready;
    assign stg_vld[0] = in_fire;
    assign stg_dat[0] = in_data;
`endif

    // Output is masked during flush so nothing is handed downstream in that cycle.
    assign out_valid = stg_vld[STAGES] && !flush;
    assign out_data  = stg_dat[STAGES];
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_fire && out_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_register.sv
// Purpose: self-checking bench for pipe_register with a queue scoreboard and occupancy model.
// Latency: checks STAGES-cycle latency and 1 word/cycle throughput.
// Backpressure: exercises full, stalled, bubble, flush, reset and random handshake traffic.
module tb_pipe_register;

    localparam int DW  = 32;
    localparam int ST  = 3;
    localparam int CW  = $clog2(ST + 2);
`ifdef PIPE_REGISTER_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = SKID ? ST + 1 : ST;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    int            n_assert  = 0;
    int            n_fail    = 0;
    int            model_cnt = 0;
    logic [31:0]   sb_q[$];

    pipe_register #(
        .DATA_WIDTH (DW),
        .STAGES     (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: samples handshakes mid-cycle, i.e. the transfers of the coming edge.
    always @(negedge clk) begin
        logic        in_fire;
        logic        out_fire;
        logic [31:0] exp_w;
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            sb_q.delete();
            model_cnt = 0;
        end else begin
            chk("count", 32'(count), 32'(model_cnt));
            if (model_cnt == 0) chk("empty_out_valid", 32'(out_valid), 32'd0);
            if (model_cnt == CAP && (SKID || !out_ready)) chk("full_in_ready", 32'(in_ready), 32'd0);
            if (flush) begin
                chk("flush_in_ready", 32'(in_ready), 32'd0);
                chk("flush_out_valid", 32'(out_valid), 32'd0);
                sb_q.delete();
                model_cnt = 0;
            end else begin
                in_fire  = in_valid && in_ready;
                out_fire = out_valid && out_ready;
                if (out_fire) begin
                    chk("out_has_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        exp_w = sb_q.pop_front();
                        chk("out_data_order", out_data, exp_w);
                    end
                    model_cnt = model_cnt - 1;
                end
                if (in_fire) begin
                    sb_q.push_back(in_data);
                    model_cnt = model_cnt + 1;
                end
            end
        end
    end

    initial begin
        int  idx;
        int  seq;
        bit  acc;
        bit  done;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        #2 rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream: stalled words must never emerge
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx       = 0;
        in_data   = 32'h100;
        repeat (5) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                in_data = 32'h100 + idx;
            end
        end
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        @(negedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("postrst_count", 32'(count), 32'd0);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);

        // Latency and throughput, out_ready high
        tick();
        in_valid = 1'b1;
        in_data  = 32'h1;
        tick();
        in_data  = 32'h2;
        tick();
        in_data  = 32'h3;
        @(negedge clk);
        chk("lat_early_out_valid", 32'(out_valid), 32'd0);
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_w1_valid", 32'(out_valid), 32'd1);
        chk("lat_w1_data", out_data, 32'h1);
        @(negedge clk);
        chk("thr_w2_valid", 32'(out_valid), 32'd1);
        chk("thr_w2_data", out_data, 32'h2);
        @(negedge clk);
        chk("thr_w3_valid", 32'(out_valid), 32'd1);
        chk("thr_w3_data", out_data, 32'h3);
        @(negedge clk);
        chk("thr_done_valid", 32'(out_valid), 32'd0);

        // Fill and backpressure
        tick();
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        in_data   = 32'h10;
        repeat (6) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx == 4) in_valid = 1'b0;
                else          in_data  = 32'h10 + idx;
            end
        end
        @(negedge clk);
        chk("fill_accepted", 32'(idx), SKID ? 32'd4 : 32'd3);
        chk("fill_count", 32'(count), 32'(CAP));
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head_valid", 32'(out_valid), 32'd1);
        chk("fill_head_data", out_data, 32'h10);
        tick();
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (idx == 4 && count == 0) begin
                done = 1'b1;
            end else begin
                acc = in_valid && in_ready;
                tick();
                if (acc) begin
                    idx++;
                    if (idx == 4) in_valid = 1'b0;
                    else          in_data  = 32'h10 + idx;
                end
            end
        end
        chk("fill_drained", 32'(done), 32'd1);

        // Bubble collapse
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_valid  = 1'b0;
        tick();
        in_valid  = 1'b1;
        in_data   = 32'hB;
        tick();
        in_valid  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("bubble_count", 32'(count), 32'd2);
        chk("bubble_head_data", out_data, 32'hA);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bubble_a_valid", 32'(out_valid), 32'd1);
        chk("bubble_a_data", out_data, 32'hA);
        tick();
        @(negedge clk);
        chk("bubble_b_valid", 32'(out_valid), 32'd1);
        chk("bubble_b_data", out_data, 32'hB);
        tick();
        @(negedge clk);
        chk("bubble_empty", 32'(out_valid), 32'd0);

        // Flush with two words in flight
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h21;
        tick();
        in_data   = 32'h22;
        tick();
        in_valid  = 1'b0;
        tick();
        @(negedge clk);
        chk("preflush_count", 32'(count), 32'd2);
        tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h77;
        @(negedge clk);
        chk("flush_pulse_in_ready", 32'(in_ready), 32'd0);
        chk("flush_pulse_out_valid", 32'(out_valid), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("postflush_count", 32'(count), 32'd0);
        chk("postflush_out_valid", 32'(out_valid), 32'd0);
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("postflush_quiet", 32'(out_valid), 32'd0);

        // Random stress; the scoreboard checks order and count on every cycle
        seq      = 0;
        in_data  = 32'h8000_0000;
        in_valid = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                seq++;
                in_data = 32'h8000_0000 + seq;
            end
            if (acc || !in_valid) in_valid = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < ((c < 5000) ? 70 : 30));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (count == 0 && sb_q.size() == 0) done = 1'b1;
            else tick();
        end
        chk("random_drained", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
